// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_pkg
//  Description : Shared encodings for the two-requester mux arbiter:
//                source codes, output-register FSM states and the
//                round-robin grant helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

    // Requester identity; also the o_src / sel / last_grant encoding
    typedef logic src_t;

    localparam src_t SRC_X = 1'b0;
    localparam src_t SRC_Y = 1'b1;

    // Output register occupancy
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    // Single requester wins outright; on contention the one that did not
    // win last time goes next. The result is ignored when nobody requests.
    function automatic src_t pick_grant(input logic xv, input logic yv,
                                        input src_t last);
        src_t g;
        if (xv && yv) begin
            g = (last == SRC_X) ? SRC_Y : SRC_X;
        end else if (yv) begin
            g = SRC_Y;
        end else begin
            g = SRC_X;
        end
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux2_dp.sv
`default_nettype none
// ============================================================================
//  Module      : mux2_dp
//  Description : WIDTH-wide combinational 2:1 payload select.
//                sel = 0 passes d0 (X), sel = 1 passes d1 (Y).
//  Revision    : 1.0 - initial release
// ============================================================================
module mux2_dp #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             sel,
    output logic [WIDTH-1:0] q
);

    // Plain 2:1 select, no state
    always_comb begin
        q = sel ? d1 : d0;
    end

endmodule
`default_nettype wire

// File: rtl/mux_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mux_arbiter
//  Description : Two-requester valid/ready arbiter feeding a single output
//                register. Alternating grant on contention, full-throughput
//                back-to-back transfers, per-requester transfer counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_arbiter
    import mux_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             x_valid,
    input  logic [WIDTH-1:0] x_data,
    output logic             x_ready,
    input  logic             y_valid,
    input  logic [WIDTH-1:0] y_data,
    output logic             y_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_src,
    input  logic             o_ready,
    output logic             sel,
    output logic [CNT_W-1:0] x_cnt,
    output logic [CNT_W-1:0] y_cnt
);

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_data;
    src_t             r_src;
    src_t             r_last_grant;
    src_t             r_sel;
    logic [CNT_W-1:0] r_x_cnt;
    logic [CNT_W-1:0] r_y_cnt;

    logic             w_load_en;
    logic             w_any_req;
    src_t             w_grant;
    src_t             w_sel;
    logic             w_x_xfer;
    logic             w_y_xfer;
    logic             w_xfer;
    logic [WIDTH-1:0] w_mux_data;

    // Arbitration and handshake: a new word may enter whenever the output
    // register is empty or is being drained this cycle
    always_comb begin
        w_load_en = (r_state == ST_EMPTY) || o_ready;
        w_any_req = x_valid || y_valid;
        w_grant   = pick_grant(x_valid, y_valid, r_last_grant);
        w_sel     = w_any_req ? w_grant : r_sel;
        x_ready   = rst_n && w_load_en && w_any_req && (w_grant == SRC_X);
        y_ready   = rst_n && w_load_en && w_any_req && (w_grant == SRC_Y);
        w_x_xfer  = x_valid && x_ready;
        w_y_xfer  = y_valid && y_ready;
        w_xfer    = w_x_xfer || w_y_xfer;
    end

    mux2_dp #(
        .WIDTH (WIDTH)
    ) u_mux2_dp (
        .d0  (x_data),
        .d1  (y_data),
        .sel (w_sel),
        .q   (w_mux_data)
    );

    // Output register occupancy: fill on any transfer, drain when the
    // consumer takes the word and nothing replaces it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_xfer) r_state <= ST_FULL;
                ST_FULL:  if (o_ready && !w_xfer) r_state <= ST_EMPTY;
                default:  r_state <= ST_EMPTY;
            endcase
        end
    end

    // Payload and source capture on transfer; held otherwise
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data <= '0;
            r_src  <= SRC_X;
        end else if (w_xfer) begin
            r_data <= w_mux_data;
            r_src  <= w_grant;
        end
    end

    // Fairness history: Y after reset so X wins the first contest
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_grant <= SRC_Y;
        end else if (w_xfer) begin
            r_last_grant <= w_grant;
        end
    end

    // Remember the select so it holds steady through idle cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sel <= SRC_X;
        end else begin
            r_sel <= w_sel;
        end
    end

    // Accepted-transfer counters, free-running wrap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x_cnt <= '0;
            r_y_cnt <= '0;
        end else begin
            if (w_x_xfer) r_x_cnt <= r_x_cnt + 1'b1;
            if (w_y_xfer) r_y_cnt <= r_y_cnt + 1'b1;
        end
    end

    assign o_valid = (r_state == ST_FULL);
    assign o_data  = r_data;
    assign o_src   = r_src;
    assign sel     = w_sel;
    assign x_cnt   = r_x_cnt;
    assign y_cnt   = r_y_cnt;

endmodule
`default_nettype wire
